// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared widths, FSM encoding and result clamp for conv3x3_stream.
// Revision : 1.0
// ============================================================================
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int W_W    = 8;
    localparam int PROD_W = 17;
    localparam int ACC_W  = 21;
    localparam int N_TAPS = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } conv_state_e;

    // Rectify negatives to 0 and saturate anything above 255.
    function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [ACC_W-1:0] v);
        logic [PIX_W-1:0] r;
        if (v[ACC_W-1]) begin
            r = '0;
        end else if (|v[ACC_W-2:PIX_W]) begin
            r = '1;
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Brief    : Enable-gated pixel delay line, DEPTH beats long (one image row).
// Revision : 1.0
// ============================================================================
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 28
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_dout
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream
// Brief    : Raster-stream 3x3 convolution, 2-stage MAC, clamp and pooling En.
// Revision : 1.0
// ============================================================================
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix,
    input  logic             weight_load,
    input  logic [3:0]       weight_idx,
    input  logic [W_W-1:0]   weight_data,
    output logic [PIX_W-1:0] convResult,
    output logic             conv_valid,
    output logic             En,
    output logic             frame_done,
    output logic             busy
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_H - 1);

    conv_state_e              r_state;
    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;
    logic [COL_W-1:0]         w_col;
    logic [ROW_W-1:0]         w_row;
    logic                     w_accept;
    logic                     w_win_done;
    logic                     w_last;
    logic [PIX_W-1:0]         w_l1;
    logic [PIX_W-1:0]         w_l2;
    logic [PIX_W-1:0]         w_tap [3];
    logic [PIX_W-1:0]         r_wa  [3];
    logic [PIX_W-1:0]         r_wb  [3];
    logic [PIX_W-1:0]         w_win [N_TAPS];
    logic signed [W_W-1:0]    r_weight [N_TAPS];
    logic signed [PROD_W-1:0] r_prod   [N_TAPS];
    logic                     r_v1;
    logic [1:0]               r_oc1;
    logic [1:0]               r_run;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_shift;

    // A SOF beat is pixel (0,0) regardless of where the counters stand.
    assign w_accept   = pix_valid && ((r_state == ST_RUN) || (r_state == ST_IDLE && pix_sof));
    assign w_col      = pix_sof ? '0 : r_col;
    assign w_row      = pix_sof ? '0 : r_row;
    assign w_win_done = w_accept && (w_col >= COL_W'(2)) && (w_row >= ROW_W'(2));
    assign w_last     = (w_col == c_COL_LAST) && (w_row == c_ROW_LAST);

    line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_din  (pix),
        .o_dout (w_l1)
    );

    line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_din  (w_l1),
        .o_dout (w_l2)
    );

    // Window row 0 is the oldest image row; column 2 is the live tap.
    always_comb begin
        w_tap[0] = w_l2;
        w_tap[1] = w_l1;
        w_tap[2] = pix;
        for (int r = 0; r < 3; r++) begin
            w_win[r*3 + 0] = r_wa[r];
            w_win[r*3 + 1] = r_wb[r];
            w_win[r*3 + 2] = w_tap[r];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_wa[r] <= r_wb[r];
                r_wb[r] <= w_tap[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_win_done) begin
            for (int k = 0; k < N_TAPS; k++) begin
                r_prod[k] <= PROD_W'(r_weight[k]) * PROD_W'($signed({1'b0, w_win[k]}));
            end
        end
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            w_acc = w_acc + ACC_W'(r_prod[k]);
        end
    end

    assign w_shift = w_acc >>> SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                r_weight[k] <= (k == 4) ? W_W'(1 << SHIFT) : '0;
            end
        end else if (r_state == ST_IDLE && weight_load) begin
            for (int k = 0; k < N_TAPS; k++) begin
                if (weight_idx == 4'(k)) begin
                    r_weight[k] <= weight_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_v1       <= 1'b0;
            r_oc1      <= '0;
            r_run      <= '0;
            convResult <= '0;
            conv_valid <= 1'b0;
            En         <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_v1 <= w_win_done;
            if (w_win_done) begin
                r_oc1 <= w_col[1:0] - 2'd2;
            end
            conv_valid <= r_v1;
            if (r_v1) begin
                convResult <= clamp_u8(w_shift);
            end
            // r_run is the gap-free result count ending this cycle, saturating at 3.
            En    <= r_v1 && (r_oc1 == 2'd3) && (r_run == 2'd3);
            r_run <= r_v1 ? ((r_run == 2'd3) ? 2'd3 : r_run + 2'd1) : 2'd0;

            if (w_accept) begin
                if (w_last) begin
                    r_col <= '0;
                    r_row <= '0;
                end else if (w_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end

            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept && w_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Final window always sits in the product stage here; it emits with frame_done.
                    r_state    <= ST_IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 convolution stage that sits directly upstream of the pooling stage. It takes a raster-scan 8-bit pixel stream and keeps the two previous image rows in line buffers. For every fully-covered 3x3 window it emits one 8-bit rectified, saturated result on `convResult`, plus the `En` strobe that tells the pooling stage when four consecutive results are valid on its inputs.

## Interface
- `IMG_W`, 28, image width in pixels (≥ 3)
- `IMG_H`, 28, image height in pixels (≥ 3)
- `SHIFT`, 4, arithmetic right shift applied to the accumulator (0..6)
- `clk` in 1: single clock; all state updates on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `pix_valid` in 1: pixel beat present this cycle
- `pix_sof` in 1: qualifies `pix_valid`; marks pixel (0,0) of a frame
- `pix` in 8: unsigned pixel
- `weight_load` in 1: write one kernel weight (honoured only in IDLE)
- `weight_idx` in 4: kernel index 0..8, raster order (0 = top-left); 9..15 ignored
- `weight_data` in 8: signed two's-complement weight
- `convResult` out 8: unsigned result; holds its value between valid cycles
- `conv_valid` out 1: `convResult` is new this cycle
- `En` out 1: pooling enable; fourth result of an aligned, gap-free group
- `frame_done` out 1: one-cycle pulse when the last result of a frame leaves the pipe
- `busy` out 1: state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `pix_valid && pix_sof`. That pixel is accepted as (0,0).
  - RUN → DRAIN after accepting pixel (IDLE_W−1, IMG_H−1).
  - DRAIN → IDLE when the pipeline is empty; `frame_done` pulses that cycle.
- In IDLE, `pix_valid` without `pix_sof` is discarded.
- In RUN, `pix_sof` restarts the frame: counters return to (0,0) at that pixel, and line-buffer contents are treated as stale. Results already in the pipe still emit. No `frame_done` is issued for the aborted frame.
- Column and row counters advance on accepted beats only. Column wraps at IMG_W−1; row increments on each wrap.
- Line buffers: two IMG_W-deep 8-bit delay lines, written on every accepted beat. Three 3-wide window shift registers are fed from pix, line1 and line2.
- A window is complete when the accepted pixel has col ≥ 2 and row ≥ 2. There is no padding. Each frame yields exactly (IMG_W−2)·(IMG_H−2) results.
- Arithmetic:
  - Each product is signed 8 × unsigned 8, 17-bit signed.
  - The nine products are summed into a 21-bit signed accumulator.
  - The accumulator is shifted right arithmetically (`>>>`) by SHIFT.
  - The result is clamped: < 0 gives 0; > 255 gives 255; otherwise the low 8 bits.
- Weights:
  - Stored in a 9-entry register file.
  - Reset value: all 0 except index 4 = 1 << SHIFT (identity kernel).
  - `weight_load` outside IDLE is ignored.
- `En` logic:
  - `run` counts consecutive `conv_valid` cycles and clears on any cycle without `conv_valid`. `out_col` is the output column, 0..IMG_W−3, and wraps per output row.
  - `En` = `conv_valid && out_col[1:0] == 3 && run ≥ 3`. Groups broken by input gaps, or rows whose width is not a multiple of 4 at the tail, produce no `En`.

## Timing
- Pipeline has 2 stages: products are registered, then sum/shift/clamp is registered.
- `conv_valid` rises exactly 2 cycles after the accepted beat that completes a window. `En` and `frame_done` are aligned with it.
- At most 1 result per cycle; full throughput when `pix_valid` is held high.
- Simultaneous `weight_load` and `pix_sof` in IDLE: both are honoured. The new weight applies starting with the first window.
- Reset (asynchronous, any time):
  - State is IDLE; counters and `run` are 0.
  - `convResult`, `conv_valid`, `En`, `frame_done`, `busy` are 0.
  - Weights return to the identity kernel.
  - Pipeline contents are discarded; no result emits after reset release until a new frame.
- Line-buffer RAM contents need no reset.

## Structure
- Package `conv_pkg`:
  - state enum `conv_state_e`
  - `PIX_W` = 8, `W_W` = 8, `PROD_W` = 17, `ACC_W` = 21
  - `clamp_u8()` function
- Sub-module `line_buffer` (parameter DEPTH, 8-bit, enable-gated delay line), instantiated twice.
- The top level holds the FSM, counters, window registers, MAC pipeline and `En` logic.

## Test plan
- **Identity kernel after reset**, IMG_W = IMG_H = 6, continuous stream with pixel = row·6+col.
  - 16 results: 7, 8, 9, 10, 13, …, 28.
  - `En` on results 10, 16, 22, 28.
  - `frame_done` 2 cycles after the last input.
- **Saturation:** all weights +1, SHIFT = 0, all pixels 200 → every result 255.
- **Negative clamp:** all weights −1, pixels 50 → every result 0.
- **Input gap:** deassert `pix_valid` for 1 cycle mid-row.
  - Results are unchanged.
  - `run` resets, and the group straddling the gap produces no `En`.
- **Weight-load gating:** `weight_load` (idx 4, data 0) during RUN is ignored; results stay identity.
- **Reset mid-frame:** assert `rst_n` low for 1 cycle, then restart with SOF.
  - Outputs are 0 during and after reset until the new frame's first window.
  - The new frame is correct.
